ldtu_ser_receiver: RTL



---
 rtl/ldtu_ser_receiver_if.sv | 37 +++
 rtl/ldtu_ser_receiver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ldtu_ser_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ldtu_ser_receiver_if : serial-in / parallel-out signal bundle for one lane  |
// | Optional bitslip input when LDTU_RX_BITSLIP_EN is defined.   Rev 1.0       |
// +----------------------------------------------------------------------------+
interface ldtu_ser_receiver_if;
  logic        DataIn;
  logic        resync;
`ifdef LDTU_RX_BITSLIP_EN
  logic        bitslip;
`endif
  logic [31:0] DataOut;
  logic        DataValid;
  logic        sync_seen;
  logic        locked;

`ifdef LDTU_RX_BITSLIP_EN
  modport master (
    output DataIn, resync, bitslip,
    input  DataOut, DataValid, sync_seen, locked
  );
  modport slave (
    input  DataIn, resync, bitslip,
    output DataOut, DataValid, sync_seen, locked
  );
`else
  modport master (
    output DataIn, resync,
    input  DataOut, DataValid, sync_seen, locked
  );
  modport slave (
    input  DataIn, resync,
    output DataOut, DataValid, sync_seen, locked
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ldtu_ser_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ldtu_ser_receiver : LiTE-DTU lane receiver, sync-word alignment + deframing |
// | Optional feature macro: LDTU_RX_BITSLIP_EN.                  Rev 1.0       |
// +----------------------------------------------------------------------------+
module ldtu_ser_receiver #(
  parameter int unsigned           WORD_BITS = 32,
  parameter logic [WORD_BITS-1:0]  SYNC_WORD = 32'hEAAAAAAA,
  parameter int unsigned           N_CONFIRM = 3
) (
  input  wire                clock,
  input  wire                rst_b,
  ldtu_ser_receiver_if.slave rx
);

  localparam logic [4:0] C_LAST_BIT     = 5'(WORD_BITS - 1);
  localparam logic [3:0] C_CONF_TARGET  = 4'(N_CONFIRM);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WORD_BITS-1:0] r_sr;
  logic [4:0]           r_bit_cnt;
  logic [4:0]           w_bit_cnt_nxt;
  logic [3:0]           r_conf_cnt;
  logic [3:0]           w_conf_cnt_nxt;
  logic [WORD_BITS-1:0] r_data_out;
  logic [WORD_BITS-1:0] w_data_out_nxt;
  logic                 r_data_valid;
  logic                 w_data_valid_nxt;
  logic                 r_sync_seen;
  logic                 w_sync_seen_nxt;
  logic                 w_sr_is_sync;
  logic                 w_slip;
  logic                 w_boundary;

`ifdef LDTU_RX_BITSLIP_EN
  assign w_slip = rx.bitslip && (r_state != ST_HUNT);
`else
  assign w_slip = 1'b0;
`endif

  assign w_sr_is_sync = (r_sr == SYNC_WORD);
  // A slip holds the counter on 31, so the boundary is taken one clock later.
  assign w_boundary   = (r_state != ST_HUNT) && (r_bit_cnt == C_LAST_BIT) && !w_slip;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_sr <= '0;
    end else begin
      r_sr <= {r_sr[WORD_BITS-2:0], rx.DataIn};
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_bit_cnt    <= '0;
      r_conf_cnt   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_sync_seen  <= 1'b0;
    end else begin
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_conf_cnt   <= w_conf_cnt_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_sync_seen  <= w_sync_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = w_slip ? r_bit_cnt : r_bit_cnt + 5'd1;
    w_conf_cnt_nxt   = r_conf_cnt;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = 1'b0;
    w_sync_seen_nxt  = 1'b0;

    case (r_state)
      ST_HUNT: begin
        w_bit_cnt_nxt = '0;
        if (w_sr_is_sync) begin
          w_conf_cnt_nxt = 4'd1;
          w_state_nxt    = (C_CONF_TARGET <= 4'd1) ? ST_LOCKED : ST_CONFIRM;
        end
      end

      ST_CONFIRM: begin
        if (w_boundary) begin
          if (w_sr_is_sync) begin
            if ((r_conf_cnt + 4'd1) >= C_CONF_TARGET) begin
              w_conf_cnt_nxt = C_CONF_TARGET;
              w_state_nxt    = ST_LOCKED;
            end else begin
              w_conf_cnt_nxt = r_conf_cnt + 4'd1;
            end
          end else begin
            w_conf_cnt_nxt = '0;
            w_state_nxt    = ST_HUNT;
          end
        end
      end

      ST_LOCKED: begin
        // Once locked, payload words never drop lock; only resync or reset do.
        if (w_boundary) begin
          w_data_out_nxt   = r_sr;
          w_data_valid_nxt = 1'b1;
          w_sync_seen_nxt  = w_sr_is_sync;
        end
      end

      default: begin
        w_state_nxt    = ST_HUNT;
        w_bit_cnt_nxt  = '0;
        w_conf_cnt_nxt = '0;
      end
    endcase

    if (rx.resync) begin
      w_state_nxt      = ST_HUNT;
      w_bit_cnt_nxt    = '0;
      w_conf_cnt_nxt   = '0;
      w_data_out_nxt   = r_data_out;
      w_data_valid_nxt = 1'b0;
      w_sync_seen_nxt  = 1'b0;
    end
  end

  assign rx.DataOut   = r_data_out;
  assign rx.DataValid = r_data_valid;
  assign rx.sync_seen = r_sync_seen;
  assign rx.locked    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire
